id_ex_stage: RTL and testbench

- ID/EX pipeline register for the 5-stage MIPS core, directly downstream of the decode control unit.
- Captures the packed control word, register-file read data, sign-extended immediate and register fields each cycle.
- Contains the load-use hazard detector: inserts one bubble and stalls PC and IF/ID.
- Also handles branch/jump flush and a global freeze for memory wait.

---
 rtl/id_ex_stage.sv | 161 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 5-stage MIPS core.
// Captures decode control, operands and register fields; detects load-use
// hazards (one bubble + PC/IF-ID stall), squashes on branch/jump flush and
// holds everything while the memory system freezes the pipe.
// Optional build macro: ID_EX_STALL_CNT_EN adds saturating stall/flush counters.
//
// Flow control: the stage always accepts the ID instruction unless freeze_i
// holds the pipe or a load-use hazard turns the capture into a bubble; in both
// cases pc_write_o/ifid_write_o drop so upstream re-presents the same
// instruction next cycle.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       ctrl_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] rt_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              flush_i,
    input  logic              freeze_i,
    output logic              RegDst_o,
    output logic              ALUSrc_o,
    output logic [1:0]        ALUOp_o,
    output logic              MemWrite_o,
    output logic              MemRead_o,
    output logic              MemtoReg_o,
    output logic              RegWrite_o,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [REG_AW-1:0] rs_o,
    output logic [REG_AW-1:0] rt_o,
    output logic [REG_AW-1:0] rd_o,
    output logic              valid_o,
    output logic              hazard_o,
    output logic              pc_write_o,
    output logic              ifid_write_o
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt_o,
    output logic [15:0]       flush_cnt_o
`endif
);

    // Decoded fields of the incoming control word.
    logic       in_reg_dst;
    logic       in_alu_src;
    logic [1:0] in_alu_op;
    logic       in_mem_write;
    logic       in_mem_read;
    logic       in_mem_to_reg;
    logic       in_reg_write;
    logic       uses_rt;
    logic       rt_match;
    logic       rs_match;
    logic       load_bubble;
    logic       unused_ctrl;

    assign in_reg_dst    = ctrl_i[7];
    assign in_alu_src    = ctrl_i[6];
    assign in_alu_op     = ctrl_i[5:4];
    assign in_mem_write  = ctrl_i[3];
    assign in_mem_read   = ctrl_i[2];
    assign in_mem_to_reg = ctrl_i[1];
    assign in_reg_write  = ctrl_i[0];

    // Upper control bits carry nothing this stage needs.
    assign unused_ctrl = ^ctrl_i[31:8];

    // rt is read (not written) by R-type, stores and the ALUOp=11 group.
    assign uses_rt  = in_reg_dst | in_mem_write | (in_alu_op == 2'b11);
    assign rs_match = (rt_o == rs_i);
    assign rt_match = uses_rt & (rt_o == rt_i);

    // Load-use detector: EX holds a real load to a non-zero register that ID reads.
    always_comb begin
        hazard_o = MemRead_o & valid_o & (rt_o != '0) & (rs_match | rt_match)
                   & ~flush_i & ~freeze_i;
    end

    // Upstream enables: stall PC and IF/ID on a hazard or a freeze.
    always_comb begin
        pc_write_o   = ~hazard_o & ~freeze_i;
        ifid_write_o = ~hazard_o & ~freeze_i;
    end

    // Flush and hazard both turn this cycle's capture into a bubble.
    always_comb begin
        load_bubble = flush_i | hazard_o;
    end

    // Pipeline register: hold on freeze, bubble on flush/hazard, else capture.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            RegDst_o   <= 1'b0;
            ALUSrc_o   <= 1'b0;
            ALUOp_o    <= 2'b00;
            MemWrite_o <= 1'b0;
            MemRead_o  <= 1'b0;
            MemtoReg_o <= 1'b0;
            RegWrite_o <= 1'b0;
            valid_o    <= 1'b0;
            rs_data_o  <= '0;
            rt_data_o  <= '0;
            imm_o      <= '0;
            rs_o       <= '0;
            rt_o       <= '0;
            rd_o       <= '0;
        end else if (!freeze_i) begin
            // Data and fields are don't-care in a bubble; loading them keeps the mux small.
            rs_data_o <= rs_data_i;
            rt_data_o <= rt_data_i;
            imm_o     <= imm_i;
            rs_o      <= rs_i;
            rt_o      <= rt_i;
            rd_o      <= rd_i;
            if (load_bubble) begin
                RegDst_o   <= 1'b0;
                ALUSrc_o   <= 1'b0;
                ALUOp_o    <= 2'b00;
                MemWrite_o <= 1'b0;
                MemRead_o  <= 1'b0;
                MemtoReg_o <= 1'b0;
                RegWrite_o <= 1'b0;
                valid_o    <= 1'b0;
            end else begin
                RegDst_o   <= in_reg_dst;
                ALUSrc_o   <= in_alu_src;
                ALUOp_o    <= in_alu_op;
                MemWrite_o <= in_mem_write;
                MemRead_o  <= in_mem_read;
                MemtoReg_o <= in_mem_to_reg;
                RegWrite_o <= in_reg_write;
                valid_o    <= 1'b1;
            end
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    // Saturating counters of hazard bubbles and flushes actually taken.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else if (!freeze_i) begin
            if (hazard_o && (stall_cnt_o != 16'hFFFF)) begin
                stall_cnt_o <= stall_cnt_o + 16'd1;
            end
            if (flush_i && (flush_cnt_o != 16'hFFFF)) begin
                flush_cnt_o <= flush_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed bench for id_ex_stage with an instruction-level
// reference model, an every-cycle compare process and literal spot checks.
module tb_id_ex_stage;
    localparam int DW = 32;
    localparam int AW = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0]   ctrl = '0;
    logic [DW-1:0] rs_data = '0, rt_data = '0, imm = '0;
    logic [AW-1:0] rs = '0, rt = '0, rd = '0;
    logic          flush = 1'b0, freeze = 1'b0;

    logic          reg_dst, alu_src, mem_write, mem_read, mem_to_reg, reg_write;
    logic [1:0]    alu_op;
    logic [DW-1:0] rs_data_q, rt_data_q, imm_q;
    logic [AW-1:0] rs_q, rt_q, rd_q;
    logic          valid, hazard, pc_write, ifid_write;
`ifdef ID_EX_STALL_CNT_EN
    logic [15:0]   stall_cnt, flush_cnt;
`endif

    id_ex_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk_i(clk), .rst_i(rst), .ctrl_i(ctrl),
        .rs_data_i(rs_data), .rt_data_i(rt_data), .imm_i(imm),
        .rs_i(rs), .rt_i(rt), .rd_i(rd),
        .flush_i(flush), .freeze_i(freeze),
        .RegDst_o(reg_dst), .ALUSrc_o(alu_src), .ALUOp_o(alu_op),
        .MemWrite_o(mem_write), .MemRead_o(mem_read), .MemtoReg_o(mem_to_reg),
        .RegWrite_o(reg_write),
        .rs_data_o(rs_data_q), .rt_data_o(rt_data_q), .imm_o(imm_q),
        .rs_o(rs_q), .rt_o(rt_q), .rd_o(rd_q),
        .valid_o(valid), .hazard_o(hazard), .pc_write_o(pc_write),
        .ifid_write_o(ifid_write)
`ifdef ID_EX_STALL_CNT_EN
        , .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
`endif
    );

    // ---------------- scoreboard counters ----------------
    int tests = 0;
    int fails = 0;
    bit done  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The EX slot is modelled as "which instruction sits there": its control
    // byte, operands and fields, plus whether it is a real instruction.
    logic [7:0]    m_ctrl = '0;
    logic          m_valid = 1'b0;
    logic [DW-1:0] m_rs_data = '0, m_rt_data = '0, m_imm = '0;
    logic [AW-1:0] m_rs = '0, m_rt = '0, m_rd = '0;
    logic [15:0]   m_stall_cnt = '0, m_flush_cnt = '0;

    // Does the ID instruction read its rt field?
    function automatic bit id_reads_rt();
        return ctrl[7] || ctrl[3] || (ctrl[5:4] == 2'b11);
    endfunction

    // A stall is needed when EX is a real load to a non-zero register that ID reads,
    // unless the ID instruction is being squashed or the pipe is frozen.
    function automatic bit exp_hazard();
        bit ex_is_load = m_valid && m_ctrl[2];
        bit id_reads   = (m_rt == rs) || (id_reads_rt() && (m_rt == rt));
        return ex_is_load && (m_rt != 0) && id_reads && !flush && !freeze;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ctrl <= '0; m_valid <= 1'b0;
            m_rs_data <= '0; m_rt_data <= '0; m_imm <= '0;
            m_rs <= '0; m_rt <= '0; m_rd <= '0;
            m_stall_cnt <= '0; m_flush_cnt <= '0;
        end else if (!freeze) begin
            m_rs_data <= rs_data; m_rt_data <= rt_data; m_imm <= imm;
            m_rs <= rs; m_rt <= rt; m_rd <= rd;
            if (flush || exp_hazard()) begin
                m_ctrl  <= 8'h00;
                m_valid <= 1'b0;
            end else begin
                m_ctrl  <= ctrl[7:0];
                m_valid <= 1'b1;
            end
            if (exp_hazard() && m_stall_cnt != 16'hFFFF) m_stall_cnt <= m_stall_cnt + 16'd1;
            if (flush && m_flush_cnt != 16'hFFFF) m_flush_cnt <= m_flush_cnt + 16'd1;
        end
    end

    // ---------------- compare process (every negedge) ----------------
    initial begin
        @(negedge clk);
        forever begin
            @(negedge clk);
            if (!done) begin
                check("cmp_hazard", 32'(hazard), 32'(exp_hazard()));
                check("cmp_pc_write", 32'(pc_write), 32'(!exp_hazard() && !freeze));
                check("cmp_ifid_write", 32'(ifid_write), 32'(!exp_hazard() && !freeze));
                check("cmp_valid", 32'(valid), 32'(m_valid));
                check("cmp_ctrl", {24'h0, reg_dst, alu_src, alu_op, mem_write, mem_read,
                                   mem_to_reg, reg_write}, {24'h0, m_ctrl});
                if (m_valid) begin
                    check("cmp_rs_data", rs_data_q, m_rs_data);
                    check("cmp_rt_data", rt_data_q, m_rt_data);
                    check("cmp_imm", imm_q, m_imm);
                    check("cmp_fields", {17'h0, rs_q, rt_q, rd_q}, {17'h0, m_rs, m_rt, m_rd});
                end
`ifdef ID_EX_STALL_CNT_EN
                check("cmp_stall_cnt", {16'h0, stall_cnt}, {16'h0, m_stall_cnt});
                check("cmp_flush_cnt", {16'h0, flush_cnt}, {16'h0, m_flush_cnt});
`endif
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [7:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] im, input logic [AW-1:0] s, input logic [AW-1:0] t,
                         input logic [AW-1:0] d, input logic fl, input logic fr);
        @(negedge clk);
        #2;
        // Upper control bits are noise the stage must ignore.
        ctrl    = ($urandom() & 32'hFFFF_FF00) | {24'h0, c};
        rs_data = a; rt_data = b; imm = im;
        rs = s; rt = t; rd = d;
        flush = fl; freeze = fr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus with literal pins ----------------
    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_rs_data", rs_data_q, 32'd0);
        check("reset_pc_write", 32'(pc_write), 32'd1);
        #1 rst = 1'b0;

        // R-type add
        drive(8'hC1, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        tick();
        check("add_regdst", 32'(reg_dst), 32'd1);
        check("add_regwrite", 32'(reg_write), 32'd1);
        check("add_aluop", 32'(alu_op), 32'd0);
        check("add_rs_data", rs_data_q, 32'd5);
        check("add_rt_data", rt_data_q, 32'd7);
        check("add_rd", 32'(rd_q), 32'd3);
        check("add_valid", 32'(valid), 32'd1);

        // Load-use: lw rt=8 then add rs=8
        drive(8'h47, 32'd100, 32'd0, 32'd4, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0);
        tick();
        check("lw_memread", 32'(mem_read), 32'd1);
        drive(8'hC1, 32'd11, 32'd12, 32'd0, 5'd8, 5'd9, 5'd10, 1'b0, 1'b0);
        #1;
        check("lu_hazard", 32'(hazard), 32'd1);
        check("lu_pc_write", 32'(pc_write), 32'd0);
        check("lu_ifid_write", 32'(ifid_write), 32'd0);
        tick();
        check("lu_bubble_valid", 32'(valid), 32'd0);
        check("lu_bubble_memread", 32'(mem_read), 32'd0);
        check("lu_bubble_regwrite", 32'(reg_write), 32'd0);
        check("lu_hazard_drop", 32'(hazard), 32'd0);
        tick();
        check("lu_add_valid", 32'(valid), 32'd1);
        check("lu_add_rs", 32'(rs_q), 32'd8);
        check("lu_add_rd", 32'(rd_q), 32'd10);

        // lw to $0 never stalls
        drive(8'h47, 32'd1, 32'd0, 32'd0, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(8'hC1, 32'd1, 32'd2, 32'd0, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0);
        #1 check("zero_no_hazard", 32'(hazard), 32'd0);
        tick();

        // ori reads only rs: rt match alone is no hazard
        drive(8'h47, 32'd1, 32'd0, 32'd0, 5'd2, 5'd8, 5'd0, 1'b0, 1'b0);
        tick();
        drive(8'h61, 32'd3, 32'd0, 32'hF, 5'd4, 5'd8, 5'd0, 1'b0, 1'b0);
        #1 check("ori_no_hazard", 32'(hazard), 32'd0);
        tick();
        check("ori_valid", 32'(valid), 32'd1);

        // sw reads rt: stall
        drive(8'h47, 32'd1, 32'd0, 32'd0, 5'd2, 5'd8, 5'd0, 1'b0, 1'b0);
        tick();
        drive(8'h48, 32'd3, 32'd9, 32'd8, 5'd3, 5'd8, 5'd0, 1'b0, 1'b0);
        #1 check("sw_hazard", 32'(hazard), 32'd1);
        tick();
        tick();
        check("sw_memwrite", 32'(mem_write), 32'd1);

        // ALUOp=11 group reads rt: stall
        drive(8'h47, 32'd1, 32'd0, 32'd0, 5'd2, 5'd8, 5'd0, 1'b0, 1'b0);
        tick();
        drive(8'h30, 32'd3, 32'd9, 32'd0, 5'd2, 5'd8, 5'd0, 1'b0, 1'b0);
        #1 check("aluop3_hazard", 32'(hazard), 32'd1);
        tick();
        tick();
        check("aluop3_aluop", 32'(alu_op), 32'd3);

        // Flush beats hazard
        drive(8'h47, 32'd1, 32'd0, 32'd0, 5'd2, 5'd8, 5'd0, 1'b0, 1'b0);
        tick();
        drive(8'hC1, 32'd3, 32'd4, 32'd0, 5'd8, 5'd9, 5'd1, 1'b1, 1'b0);
        #1;
        check("flush_no_hazard", 32'(hazard), 32'd0);
        check("flush_pc_write", 32'(pc_write), 32'd1);
        tick();
        check("flush_bubble_valid", 32'(valid), 32'd0);
        check("flush_bubble_regwrite", 32'(reg_write), 32'd0);

        // Freeze for three cycles while inputs change
        drive(8'h47, 32'h64, 32'd0, 32'd4, 5'd2, 5'd8, 5'd0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(8'hC1, 32'(50 + i), 32'(60 + i), 32'(i), 5'd8, 5'(i + 1), 5'(i + 2), 1'b0, 1'b1);
            #1;
            check("frz_pc_write", 32'(pc_write), 32'd0);
            check("frz_hazard", 32'(hazard), 32'd0);
            tick();
            check("frz_memread_held", 32'(mem_read), 32'd1);
            check("frz_rt_held", 32'(rt_q), 32'd8);
            check("frz_rs_data_held", rs_data_q, 32'h64);
        end
        drive(8'hC1, 32'd70, 32'd71, 32'd0, 5'd8, 5'd9, 5'd11, 1'b0, 1'b0);
        #1 check("frz_release_hazard", 32'(hazard), 32'd1);

        // Asynchronous reset mid-stall
        #1 rst = 1'b1;
        #1;
        check("rst_mid_valid", 32'(valid), 32'd0);
        check("rst_mid_memread", 32'(mem_read), 32'd0);
        check("rst_mid_hazard", 32'(hazard), 32'd0);
        check("rst_mid_pc_write", 32'(pc_write), 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        tick();
        check("post_rst_valid", 32'(valid), 32'd1);
        check("post_rst_rd", 32'(rd_q), 32'd11);

        @(negedge clk);
        done = 1'b1;
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #100000;
        fails++;
        $display("FAIL timeout: got running expected finished");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
